// File: rtl/gate_chk_pkg.sv
// rtl/gate_chk_pkg.sv - gate_sel encodings and FSM state type for gate_vector_checker
package gate_chk_pkg;

  // Gate-under-test encodings carried on gate_sel
  localparam logic [2:0] GATE_AND   = 3'd0;
  localparam logic [2:0] GATE_OR    = 3'd1;
  localparam logic [2:0] GATE_NAND  = 3'd2;
  localparam logic [2:0] GATE_NOR   = 3'd3;
  localparam logic [2:0] GATE_XOR   = 3'd4;
  localparam logic [2:0] GATE_XNOR  = 3'd5;
  localparam logic [2:0] GATE_BUF_A = 3'd6;
  localparam logic [2:0] GATE_NOT_A = 3'd7;

  // Index of the final vector in the 00,01,10,11 sweep
  localparam logic [1:0] VEC_LAST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// rtl/gate_ref_model.sv - combinational golden output for the selected 2-input gate
module gate_ref_model
  import gate_chk_pkg::*;
(
  input  logic [2:0] i_gate_sel,
  input  logic       i_a,
  input  logic       i_b,
  output logic       o_y_exp
);

  // Truth-table lookup of the expected gate output
  always_comb begin
    o_y_exp = 1'b0;
    case (i_gate_sel)
      GATE_AND:   o_y_exp = i_a & i_b;
      GATE_OR:    o_y_exp = i_a | i_b;
      GATE_NAND:  o_y_exp = ~(i_a & i_b);
      GATE_NOR:   o_y_exp = ~(i_a | i_b);
      GATE_XOR:   o_y_exp = i_a ^ i_b;
      GATE_XNOR:  o_y_exp = ~(i_a ^ i_b);
      GATE_BUF_A: o_y_exp = i_a;
      GATE_NOT_A: o_y_exp = ~i_a;
      default:    o_y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_vector_checker.sv
// rtl/gate_vector_checker.sv - sweeps 4 input vectors into a gate and scores its output (optional GATE_CHK_OBS_TT_EN adds obs_tt)
module gate_vector_checker
  import gate_chk_pkg::*;
#(
  parameter int HOLD_CYCLES = 10
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
`ifdef GATE_CHK_OBS_TT_EN
  ,
  output logic [3:0] obs_tt
`endif
);

  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

  state_t          r_state;
  state_t          w_next_state;
  logic [1:0]      r_vec;
  logic [HC_W-1:0] r_hold_cnt;
  logic [2:0]      r_gate_sel;
  logic [2:0]      r_err_count;
  logic [3:0]      r_fail_mask;

  logic w_accept;
  logic w_sample;
  logic w_last;
  logic w_y_exp;
  logic w_mismatch;

  // start is only honoured outside a sweep; a start seen on the final DRIVE cycle is therefore dropped
  assign w_accept   = start && (r_state != ST_DRIVE);
  assign w_sample   = (r_state == ST_DRIVE) && (r_hold_cnt == HOLD_LAST);
  assign w_last     = w_sample && (r_vec == VEC_LAST);
  assign w_mismatch = w_sample && (y != w_y_exp);

  // Reference sees the vector being driven, scored against the gate latched at start
  gate_ref_model u_ref (
    .i_gate_sel (r_gate_sel),
    .i_a        (r_vec[1]),
    .i_b        (r_vec[0]),
    .o_y_exp    (w_y_exp)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state: idle/done wait for start, drive runs until the last vector is sampled
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_next_state = ST_DRIVE;
      ST_DRIVE: if (w_last) w_next_state = ST_DONE;
      ST_DONE:  if (start)  w_next_state = ST_DRIVE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: stimulus only while driving, otherwise parked at 00
  always_comb begin
    a    = 1'b0;
    b    = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_DRIVE: begin
        a    = r_vec[1];
        b    = r_vec[0];
        busy = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    pass = done && (r_err_count == 3'd0);
  end

  assign err_count = r_err_count;
  assign fail_mask = r_fail_mask;

  // Sweep datapath: vector/hold counters and accumulated score
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vec       <= 2'd0;
      r_hold_cnt  <= '0;
      r_gate_sel  <= GATE_AND;
      r_err_count <= 3'd0;
      r_fail_mask <= 4'd0;
    end else if (w_accept) begin
      r_vec       <= 2'd0;
      r_hold_cnt  <= '0;
      r_gate_sel  <= gate_sel;
      r_err_count <= 3'd0;
      r_fail_mask <= 4'd0;
    end else if (r_state == ST_DRIVE) begin
      if (w_sample) begin
        r_hold_cnt <= '0;
        r_vec      <= r_vec + 2'd1;
      end else begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
      if (w_mismatch) begin
        r_fail_mask[r_vec] <= 1'b1;
        r_err_count        <= r_err_count + 3'd1;
      end
    end
  end

`ifdef GATE_CHK_OBS_TT_EN
  logic [3:0] r_obs_tt;

  // Observed truth table: y as seen at each vector's sample point
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_obs_tt <= 4'd0;
    end else if (w_accept) begin
      r_obs_tt <= 4'd0;
    end else if (w_sample) begin
      r_obs_tt[r_vec] <= y;
    end
  end

  assign obs_tt = r_obs_tt;
`endif

endmodule

// File: tb/tb_gate_vector_checker.sv
// tb/tb_gate_vector_checker.sv - table-driven bench for gate_vector_checker (HOLD_CYCLES 10 and 1)
module tb_gate_vector_checker;

  typedef struct {
    logic       one;       // run on the HOLD_CYCLES=1 instance
    logic [2:0] sel;
    logic [3:0] mode;      // bench gate model: 0..7 as gate_sel, 8 stuck-0, 9 stuck-1
    logic       exp_pass;
    logic [2:0] exp_err;
    logic [3:0] exp_mask;
    logic [3:0] exp_obs;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start10, start1, sel_one;
  logic [2:0] gate_sel;
  logic [3:0] mode;
  logic       y10, y1;
  logic       a10, b10, busy10, done10, pass10;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err10, err1;
  logic [3:0] mask10, mask1;
  logic [3:0] obs10, obs1;

  int n_applied = 0;
  int n_miss = 0;
  vec_t tbl[13];

  gate_vector_checker #(.HOLD_CYCLES(10)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .gate_sel(gate_sel), .y(y10),
    .a(a10), .b(b10), .busy(busy10), .done(done10), .pass(pass10),
    .err_count(err10), .fail_mask(mask10)
`ifdef GATE_CHK_OBS_TT_EN
    , .obs_tt(obs10)
`endif
  );

  gate_vector_checker #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .gate_sel(gate_sel), .y(y1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_mask(mask1)
`ifdef GATE_CHK_OBS_TT_EN
    , .obs_tt(obs1)
`endif
  );

`ifndef GATE_CHK_OBS_TT_EN
  assign obs10 = 4'd0;
  assign obs1  = 4'd0;
`endif

  function automatic logic gate_model(input logic [3:0] m, input logic ia, input logic ib);
    case (m)
      4'd0: return ia & ib;
      4'd1: return ia | ib;
      4'd2: return ~(ia & ib);
      4'd3: return ~(ia | ib);
      4'd4: return ia ^ ib;
      4'd5: return ~(ia ^ ib);
      4'd6: return ia;
      4'd7: return ~ia;
      4'd9: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb y10 = gate_model(mode, a10, b10);
  always_comb y1  = gate_model(mode, a1, b1);

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [2:0] m_err;
  logic [3:0] m_mask, m_obs;
  always_comb begin
    m_a    = sel_one ? a1    : a10;
    m_b    = sel_one ? b1    : b10;
    m_busy = sel_one ? busy1 : busy10;
    m_done = sel_one ? done1 : done10;
    m_pass = sel_one ? pass1 : pass10;
    m_err  = sel_one ? err1  : err10;
    m_mask = sel_one ? mask1 : mask10;
    m_obs  = sel_one ? obs1  : obs10;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_ab_busy_done_pass"}, {4'd0, m_a, m_b, m_busy, m_done, m_pass}, 8'd0);
    check({name, "_err"},  {5'd0, m_err},  8'd0);
    check({name, "_mask"}, {4'd0, m_mask}, 8'd0);
`ifdef GATE_CHK_OBS_TT_EN
    check({name, "_obs"},  {4'd0, m_obs},  8'd0);
`endif
  endtask

  // Returns at the negedge of the first DRIVE cycle with start already dropped
  task automatic pulse_start();
    @(negedge clk);
    if (sel_one) start1 = 1'b1; else start10 = 1'b1;
    @(negedge clk);
    start1  = 1'b0;
    start10 = 1'b0;
  endtask

  task automatic run_sweep(input int idx);
    int  h, k;
    logic walk_ok;
    sel_one  = tbl[idx].one;
    gate_sel = tbl[idx].sel;
    mode     = tbl[idx].mode;
    h = tbl[idx].one ? 1 : 10;
    pulse_start();
    walk_ok = 1'b1;
    k = 0;
    while (k < 4 * h + 5 && !m_done) begin
      if (!(m_busy && ({m_a, m_b} == 2'(k / h)))) walk_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check($sformatf("v%0d_walk", idx), {7'd0, walk_ok}, 8'd1);
    check($sformatf("v%0d_done_latency", idx), 8'(k), 8'(4 * h));
    check($sformatf("v%0d_pass", idx), {7'd0, m_pass}, {7'd0, tbl[idx].exp_pass});
    check($sformatf("v%0d_err", idx), {5'd0, m_err}, {5'd0, tbl[idx].exp_err});
    check($sformatf("v%0d_mask", idx), {4'd0, m_mask}, {4'd0, tbl[idx].exp_mask});
    check($sformatf("v%0d_idle_ab_busy", idx), {5'd0, m_a, m_b, m_busy}, 8'd0);
`ifdef GATE_CHK_OBS_TT_EN
    check($sformatf("v%0d_obs", idx), {4'd0, m_obs}, {4'd0, tbl[idx].exp_obs});
`endif
  endtask

  initial begin
    int k;
    //          one   sel   mode  pass  err   mask     obs
    tbl[0]  = '{1'b0, 3'd5, 4'd5, 1'b1, 3'd0, 4'b0000, 4'b1001};
    tbl[1]  = '{1'b0, 3'd5, 4'd0, 1'b0, 3'd1, 4'b0001, 4'b1000};
    tbl[2]  = '{1'b0, 3'd0, 4'd9, 1'b0, 3'd3, 4'b0111, 4'b1111};
    tbl[3]  = '{1'b0, 3'd0, 4'd0, 1'b1, 3'd0, 4'b0000, 4'b1000};
    tbl[4]  = '{1'b0, 3'd1, 4'd8, 1'b0, 3'd3, 4'b1110, 4'b0000};
    tbl[5]  = '{1'b0, 3'd2, 4'd3, 1'b0, 3'd2, 4'b0110, 4'b0001};
    tbl[6]  = '{1'b0, 3'd4, 4'd5, 1'b0, 3'd4, 4'b1111, 4'b1001};
    tbl[7]  = '{1'b0, 3'd6, 4'd4, 1'b0, 3'd2, 4'b1010, 4'b0110};
    tbl[8]  = '{1'b0, 3'd7, 4'd2, 1'b0, 3'd1, 4'b0100, 4'b0111};
    tbl[9]  = '{1'b0, 3'd3, 4'd3, 1'b1, 3'd0, 4'b0000, 4'b0001};
    tbl[10] = '{1'b0, 3'd6, 4'd8, 1'b0, 3'd2, 4'b1100, 4'b0000};
    tbl[11] = '{1'b1, 3'd4, 4'd4, 1'b1, 3'd0, 4'b0000, 4'b0110};
    tbl[12] = '{1'b1, 3'd2, 4'd9, 1'b0, 3'd1, 4'b1000, 4'b1111};

    rst_n = 1'b0; start10 = 1'b0; start1 = 1'b0; sel_one = 1'b0;
    gate_sel = 3'd0; mode = 4'd0;
    repeat (3) @(negedge clk);
    check_reset_state("rst10");
    sel_one = 1'b1; #1;
    check_reset_state("rst1");
    sel_one = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_sweep(i);

    // Mid-sweep reset discards the partial score
    sel_one = 1'b0; gate_sel = 3'd5; mode = 4'd0;
    pulse_start();
    repeat (15) @(negedge clk);
    check("midrst_partial_err", {5'd0, err10}, 8'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("midrst");
    run_sweep(0);

    // Re-pulsed start and gate_sel change during a sweep are ignored
    sel_one = 1'b0; gate_sel = 3'd0; mode = 4'd0;
    pulse_start();
    k = 0;
    while (k < 45 && !done10) begin
      if (k == 12) gate_sel = 3'd1;
      start10 = (k == 5 || k == 20);
      @(negedge clk);
      k++;
    end
    start10 = 1'b0;
    check("repulse_latency", 8'(k), 8'd40);
    check("repulse_pass", {7'd0, pass10}, 8'd1);
    check("repulse_err", {5'd0, err10}, 8'd0);

    // start on the cycle DONE is entered is dropped; results then hold
    gate_sel = 3'd3; mode = 4'd3;
    pulse_start();
    k = 0;
    while (k < 39 && !done10) begin
      @(negedge clk);
      k++;
    end
    start10 = 1'b1;
    @(negedge clk);
    start10 = 1'b0;
    check("late_start_done", {6'd0, done10, busy10}, 8'b10);
    @(negedge clk);
    check("late_start_stays_done", {6'd0, done10, busy10}, 8'b10);
    repeat (5) @(negedge clk);
    check("done_hold", {1'b0, done10, pass10, err10, 1'b0}, {1'b0, 1'b1, 1'b1, 3'd0, 1'b0});

    // Reset wins over a simultaneous start
    rst_n = 1'b0; start10 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; start10 = 1'b0;
    check("rst_over_start", {6'd0, busy10, done10}, 8'd0);

    // HOLD_CYCLES=1: start while in DONE clears done on the next edge
    run_sweep(11);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("h1_restart", {6'd0, done1, busy1}, 8'b01);
    repeat (6) @(negedge clk);
    check("h1_restart_done", {6'd0, done1, pass1}, 8'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 Parameter HOLD_CYCLES, default 10, SHALL set the clock cycles each input vector is held; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  single-cycle request to run one 4-vector sweep.
REQ-005 gate_sel  input  3  gate under test: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 BUF_A (y=a), 7 NOT_A (y=~a).
REQ-006 y  input  1  output of the 2-input gate DUT being exercised.
REQ-007 a, b  output  1 each  stimulus driven to DUT inputs a and b.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  high from sweep completion until the next accepted start or reset.
REQ-010 pass  output  1  high with done when err_count is 0.
REQ-011 err_count  output  3  number of mismatching vectors in the last sweep, 0..4.
REQ-012 fail_mask  output  4  bit i set when vector i ({a,b}=i) mismatched.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, DRIVE, DONE.
REQ-014 In IDLE or DONE, start=1 SHALL latch gate_sel and clear err_count, fail_mask, done and pass; it SHALL set vec=0 and hold_cnt=0, then enter DRIVE.
REQ-015 In DRIVE, {a,b} SHALL equal vec, with vector order 00, 01, 10, 11.
REQ-016 hold_cnt SHALL increment each DRIVE cycle.
REQ-017 On the cycle where hold_cnt==HOLD_CYCLES-1, the block SHALL sample y and compare it with the reference value for the latched gate_sel and vec.
REQ-018 On a mismatch, the block SHALL set fail_mask[vec] and increment err_count.
REQ-019 After that sample cycle, vec SHALL increment and hold_cnt SHALL clear; when vec==3 the FSM SHALL go to DONE instead.
REQ-020 done and busy SHALL toggle on the clock edge exactly 4*HOLD_CYCLES cycles after the edge that accepted start.
REQ-021 In DONE, a and b SHALL return to 0.
REQ-022 done, pass, err_count and fail_mask SHALL hold stable in DONE.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 gate_sel changes during a sweep SHALL have no effect.
REQ-025 start asserted in the same cycle the FSM enters DONE SHALL be ignored; start is accepted from the following cycle.
REQ-026 With HOLD_CYCLES=1, each vector SHALL be driven and sampled in the same single cycle.
REQ-027 busy SHALL be 1 exactly in DRIVE.

Reset
REQ-028 rst_n=0 at any clock edge, including mid-sweep, SHALL force IDLE.
REQ-029 The reset values SHALL be a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, vec=0 and hold_cnt=0.
REQ-030 Any partial sweep result SHALL be discarded on reset.
REQ-031 rst_n SHALL take priority over start in the same cycle.

Configuration
REQ-032 Macro GATE_CHK_OBS_TT_EN defined: the block SHALL add output obs_tt[3:0].
REQ-033 With the macro defined, obs_tt bit i SHALL capture y sampled for vector i.
REQ-034 With the macro defined, obs_tt SHALL be cleared on reset and on an accepted start.
REQ-035 Macro undefined: the obs_tt port and its register SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-036 Package gate_chk_pkg SHALL hold the gate_sel encoding constants and the FSM state typedef.
REQ-037 hold_cnt width SHALL be $clog2(HOLD_CYCLES+1).
REQ-038 Sub-module gate_ref_model SHALL be purely combinational (gate_sel, a, b -> y_exp) and instantiated once.

Verification
REQ-039 Scenario: gate_sel=5 with a correct XNOR DUT and start pulse -> a,b walk 00, 01, 10, 11, each for 10 cycles; done=1 at cycle 40; pass=1; err_count=0; fail_mask=0000.
REQ-040 Scenario: gate_sel=5 with y tied to an AND DUT -> done=1; pass=0; err_count=1; fail_mask=0001.
REQ-041 Scenario: gate_sel=0 with y stuck at 1 -> err_count=3; fail_mask=0111; with GATE_CHK_OBS_TT_EN, obs_tt=1111.
REQ-042 Scenario: rst_n=0 at cycle 15 of a sweep -> next cycle busy=0, done=0, a=b=0, err_count=0; a new start then completes a full sweep normally.
REQ-043 Scenario: start re-pulsed at cycles 5 and 20 of a sweep, and gate_sel changed at cycle 12 -> no restart; result matches the gate_sel latched at the original start.
REQ-044 Scenario: HOLD_CYCLES=1, gate_sel=4 with an XOR DUT -> done at cycle 4; pass=1; start in DONE clears done on the next edge.
